// File: rtl/sequential_divider_if.sv
// Divider request/result bundle between the control FSM (master) and the divider (slave).
// Carries no state and adds no latency.
// Backpressure: none. The master watches busy/done and the divider ignores start while busy.
// Optional macro: DIVIDER_ZERO_CHECK_EN adds the div_zero result flag.
interface sequential_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
`ifdef DIVIDER_ZERO_CHECK_EN
    logic         div_zero;
`endif

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder
`ifdef DIVIDER_ZERO_CHECK_EN
        , input div_zero
`endif
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder
`ifdef DIVIDER_ZERO_CHECK_EN
        , output div_zero
`endif
    );
endinterface

// File: rtl/sequential_divider.sv
// Unsigned restoring divider that produces one quotient bit per clock from one N+1-bit trial subtraction.
// Latency: start accepted at edge k, busy is high for cycles k+1..k+N, and done pulses in cycle k+N+1.
// Backpressure: start is ignored while busy. Start in the DONE cycle is accepted back-to-back.
// Optional macro: DIVIDER_ZERO_CHECK_EN short-circuits a zero divisor to DONE and flags div_zero.
module sequential_divider #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sequential_divider_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [N-1:0]   q_q;        // dividend shifting out MSB-first, quotient bits shifting in
    logic [N-1:0]   d_q;        // latched divisor
    logic [N-1:0]   r_q;        // partial remainder; always < divisor after restore, so N bits suffice
    logic [CW-1:0]  count_q;
    logic           busy_q;
    logic           done_q;
    logic [N-1:0]   quot_q;
    logic [N-1:0]   rem_q;
`ifdef DIVIDER_ZERO_CHECK_EN
    logic           dz_q;
`endif

    logic [N:0]     shift_r;
    logic [N:0]     trial;
    logic           fits;
    logic [N-1:0]   r_d;
    logic [N-1:0]   q_d;

    // One restoring step: shift in the next dividend bit, then keep the difference only if it did not borrow.
    always_comb begin
        shift_r = {r_q, q_q[N-1]};
        trial   = shift_r - {1'b0, d_q};
        fits    = ~trial[N];
        r_d     = fits ? trial[N-1:0] : shift_r[N-1:0];
        q_d     = {q_q[N-2:0], fits};
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    if (bus.start) begin
                        q_q     <= bus.dividend;
                        d_q     <= bus.divisor;
                        r_q     <= '0;
                        count_q <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
                        dz_q    <= 1'b0;
                        if (bus.divisor == '0) begin
                            // Answer immediately with the same result the full iteration would give.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            quot_q  <= '1;
                            rem_q   <= bus.dividend;
                            dz_q    <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                S_RUN: begin
                    q_q     <= q_d;
                    r_q     <= r_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= q_d;
                        rem_q   <= r_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
`ifdef DIVIDER_ZERO_CHECK_EN
    assign bus.div_zero  = dz_q;
`endif
endmodule

// File: tb/tb_sequential_divider.sv
// Directed testbench for sequential_divider (N=8) with hand-computed expected quotients and remainders.
// Inputs are driven and outputs sampled on the falling edge, away from the active rising edge.
// Optional macro: DIVIDER_ZERO_CHECK_EN selects the short-circuit zero-divisor expectations.
module tb_sequential_divider;
    localparam int N = 8;
`ifdef DIVIDER_ZERO_CHECK_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = N + 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sequential_divider_if #(.N(N)) dif ();

    sequential_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one division, optionally pulse a stray start at cycle 'glitch', and check timing and result.
    task automatic divide(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input int elat, input int glitch);
        int cyc;
        int bcnt;
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(negedge clk);
        dif.start = 1'b0;
        cyc  = 1;
        bcnt = 0;
        while (!dif.done && cyc < 40) begin
            if (dif.busy) bcnt++;
            if (cyc == glitch) begin
                dif.start    = 1'b1;
                dif.dividend = 8'd50;
                dif.divisor  = 8'd5;
            end else begin
                dif.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        dif.start = 1'b0;
        check({tag, "_done_cycle"}, cyc, elat);
        check({tag, "_busy_cycles"}, bcnt, elat - 1);
        check({tag, "_quotient"}, dif.quotient, eq);
        check({tag, "_remainder"}, dif.remainder, er);
        @(negedge clk);
        check({tag, "_done_pulse"}, dif.done, 1'b0);
        check({tag, "_quotient_held"}, dif.quotient, eq);
    endtask

    initial begin
        int first;
        int second;

        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", dif.busy, 1'b0);
        check("rst_done", dif.done, 1'b0);
        check("rst_quotient", dif.quotient, 0);
        check("rst_remainder", dif.remainder, 0);
`ifdef DIVIDER_ZERO_CHECK_EN
        check("rst_div_zero", dif.div_zero, 1'b0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Basic and boundary operand patterns.
        divide("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, N + 1, 0);
        divide("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, N + 1, 0);
        divide("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, N + 1, 0);
        divide("d200_200", 8'd200, 8'd200, 8'd1, 8'd0, N + 1, 0);

        // Back-to-back: start held high through the first DONE cycle.
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 8'd100;
        dif.divisor  = 8'd7;
        @(negedge clk);
        dif.dividend = 8'd81;
        dif.divisor  = 8'd9;
        first  = 0;
        second = 0;
        for (int c = 1; c <= 40 && second == 0; c++) begin
            if (first != 0 && c == first + 1) begin
                check("b2b_done_drop", dif.done, 1'b0);
                check("b2b_busy_again", dif.busy, 1'b1);
            end
            if (dif.done) begin
                if (first == 0) begin
                    first = c;
                    check("b2b_q1", dif.quotient, 8'd14);
                    check("b2b_r1", dif.remainder, 8'd2);
                end else begin
                    second = c;
                    dif.start = 1'b0;
                    check("b2b_q2", dif.quotient, 8'd9);
                    check("b2b_r2", dif.remainder, 8'd0);
                end
            end
            if (second == 0) @(negedge clk);
        end
        dif.start = 1'b0;
        check("b2b_first_done", first, N + 1);
        check("b2b_spacing", second - first, N + 1);

        // Stray start while busy is ignored.
        divide("ign100_7", 8'd100, 8'd7, 8'd14, 8'd2, N + 1, 3);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 8'd100;
        dif.divisor  = 8'd7;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_pre_busy", dif.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", dif.busy, 1'b0);
        check("arst_done", dif.done, 1'b0);
        check("arst_quotient", dif.quotient, 0);
        check("arst_remainder", dif.remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;
        divide("d10_3", 8'd10, 8'd3, 8'd3, 8'd1, N + 1, 0);

        // Zero divisor.
        divide("z77_0", 8'd77, 8'd0, 8'd255, 8'd77, ZLAT, 0);
`ifdef DIVIDER_ZERO_CHECK_EN
        check("z_div_zero_set", dif.div_zero, 1'b1);
        divide("d81_9", 8'd81, 8'd9, 8'd9, 8'd0, N + 1, 0);
        check("z_div_zero_clear", dif.div_zero, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
